// File: rtl/pid_multi_ctrl.sv
// Time-multiplexed PID controller: one shared datapath serves all channels.
// Each accepted tick walks channels 0..N-1 through LOAD/MULT/SUM/WRITE.
module pid_multi_ctrl #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk_in_i,
  input  logic                      reset_i,
  input  logic                      clk_en_i,
  input  logic                      cfg_we_i,
  input  logic [CW-1:0]             cfg_ch_i,
  input  logic [2:0]                cfg_sel_i,
  input  logic [WIDTH-1:0]          cfg_data_i,
  input  logic                      sens_we_i,
  input  logic [CW-1:0]             sens_ch_i,
  input  logic [WIDTH-1:0]          sens_data_i,
  output logic [CHANNELS*WIDTH-1:0] pid_o,
  output logic [CHANNELS-1:0]       pid_valid_o,
  output logic                      busy_o,
  output logic                      overrun_o
);

  localparam int AW = 2 * WIDTH + 4;
  localparam int IW = WIDTH + 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MULT,
    SUM,
    WRITE
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] ch_q;
  logic          last_ch;
  logic          cfg_ok;
  logic          sens_ok;

  logic signed [WIDTH-1:0] kp_q  [CHANNELS];
  logic signed [WIDTH-1:0] ki_q  [CHANNELS];
  logic signed [WIDTH-1:0] kd_q  [CHANNELS];
  logic signed [WIDTH-1:0] lo_q  [CHANNELS];
  logic signed [WIDTH-1:0] up_q  [CHANNELS];
  logic        [WIDTH-1:0] sp_q  [CHANNELS];
  logic        [WIDTH-1:0] off_q [CHANNELS];
  logic        [WIDTH-1:0] sens_q[CHANNELS];
  logic signed [WIDTH-1:0] integ_q[CHANNELS];
  logic signed [WIDTH:0]   eprev_q[CHANNELS];

  // per-channel snapshot taken in LOAD
  logic signed [WIDTH-1:0] s_kp, s_ki, s_kd;
  logic signed [WIDTH-1:0] s_lo, s_up;
  logic        [WIDTH-1:0] s_off;
  logic signed [WIDTH:0]   e_r;

  logic signed [WIDTH-1:0] inew_r;
  logic signed [AW-1:0]    pe_r, pi_r, pd_r;
  logic        [WIDTH-1:0] out_r;

  logic signed [IW-1:0]    isum, deriv;
  logic                    hi_hit, lo_hit;
  logic signed [WIDTH-1:0] inew;
  logic signed [AW-1:0]    acc, sh;
  logic signed [AW:0]      osum;
  logic        [WIDTH-1:0] osat;

  assign busy_o  = (state_q != IDLE);
  assign last_ch = (int'(ch_q) == CHANNELS - 1);
  assign cfg_ok  = cfg_we_i && (int'(cfg_ch_i) < CHANNELS);
  assign sens_ok = sens_we_i && (int'(sens_ch_i) < CHANNELS);

  always_ff @(posedge clk_in_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int k = 0; k < CHANNELS; k++) begin
        kp_q[k]  <= '0;
        ki_q[k]  <= '0;
        kd_q[k]  <= '0;
        sp_q[k]  <= '0;
        off_q[k] <= '0;
        lo_q[k]  <= {1'b1, {(WIDTH-1){1'b0}}};
        up_q[k]  <= {1'b0, {(WIDTH-1){1'b1}}};
      end
    end else if (cfg_ok) begin
      unique case (cfg_sel_i)
        3'd0:    kp_q[cfg_ch_i]  <= cfg_data_i;
        3'd1:    ki_q[cfg_ch_i]  <= cfg_data_i;
        3'd2:    kd_q[cfg_ch_i]  <= cfg_data_i;
        3'd3:    sp_q[cfg_ch_i]  <= cfg_data_i;
        3'd4:    lo_q[cfg_ch_i]  <= cfg_data_i;
        3'd5:    up_q[cfg_ch_i]  <= cfg_data_i;
        3'd6:    off_q[cfg_ch_i] <= cfg_data_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int k = 0; k < CHANNELS; k++) begin
        sens_q[k] <= '0;
      end
    end else if (sens_ok) begin
      sens_q[sens_ch_i] <= sens_data_i;
    end
  end

  always_ff @(posedge clk_in_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (clk_en_i) state_d = LOAD;
      LOAD:    state_d = MULT;
      MULT:    state_d = SUM;
      SUM:     state_d = WRITE;
      WRITE:   state_d = last_ch ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  // integrator clamp: upper bound checked first, lower bound has last word
  always_comb begin
    isum   = IW'(integ_q[ch_q]) + IW'(e_r);
    deriv  = IW'(e_r) - IW'(eprev_q[ch_q]);
    hi_hit = isum > IW'(s_up);
    lo_hit = hi_hit ? (s_up < s_lo) : (isum < IW'(s_lo));
    inew   = isum[WIDTH-1:0];
    if (lo_hit) begin
      inew = s_lo;
    end else if (hi_hit) begin
      inew = s_up;
    end
  end

  always_comb begin
    acc  = pe_r + pi_r + pd_r;
    sh   = acc >>> FRAC;
    osum = (AW+1)'(sh) + $signed((AW+1)'(s_off));
    osat = osum[WIDTH-1:0];
    if (osum < 0) begin
      osat = '0;
    end else if (osum > $signed((AW+1)'({WIDTH{1'b1}}))) begin
      osat = '1;
    end
  end

  always_ff @(posedge clk_in_i or negedge reset_i) begin
    if (!reset_i) begin
      ch_q        <= '0;
      overrun_o   <= 1'b0;
      pid_valid_o <= '0;
      pid_o       <= '0;
      s_kp        <= '0;
      s_ki        <= '0;
      s_kd        <= '0;
      s_lo        <= '0;
      s_up        <= '0;
      s_off       <= '0;
      e_r         <= '0;
      inew_r      <= '0;
      pe_r        <= '0;
      pi_r        <= '0;
      pd_r        <= '0;
      out_r       <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        integ_q[k] <= '0;
        eprev_q[k] <= '0;
      end
    end else begin
      pid_valid_o <= '0;
      if (clk_en_i && busy_o) begin
        overrun_o <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          ch_q <= '0;
        end
        LOAD: begin
          s_kp  <= kp_q[ch_q];
          s_ki  <= ki_q[ch_q];
          s_kd  <= kd_q[ch_q];
          s_lo  <= lo_q[ch_q];
          s_up  <= up_q[ch_q];
          s_off <= off_q[ch_q];
          e_r   <= $signed({1'b0, sp_q[ch_q]})
                 - $signed({1'b0, sens_q[ch_q]});
        end
        MULT: begin
          inew_r <= inew;
          pe_r   <= AW'(s_kp) * AW'(e_r);
          pi_r   <= AW'(s_ki) * AW'(inew);
          pd_r   <= AW'(s_kd) * AW'(deriv);
        end
        SUM: begin
          out_r <= osat;
        end
        WRITE: begin
          integ_q[ch_q]             <= inew_r;
          eprev_q[ch_q]             <= e_r;
          pid_o[ch_q*WIDTH +: WIDTH] <= out_r;
          pid_valid_o[ch_q]         <= 1'b1;
          if (!last_ch) begin
            ch_q <= ch_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_multi_ctrl.sv
// Bench for pid_multi_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a time-based arithmetic model.
module tb_pid_multi_ctrl;

  localparam int C = 4;
  localparam int W = 16;
  localparam int F = 8;

  logic          clk_in_i = 1'b0;
  logic          reset_i;
  logic          clk_en_i;
  logic          cfg_we_i;
  logic [1:0]    cfg_ch_i;
  logic [2:0]    cfg_sel_i;
  logic [W-1:0]  cfg_data_i;
  logic          sens_we_i;
  logic [1:0]    sens_ch_i;
  logic [W-1:0]  sens_data_i;
  logic [C*W-1:0] pid_o;
  logic [C-1:0]  pid_valid_o;
  logic          busy_o;
  logic          overrun_o;

  pid_multi_ctrl #(.CHANNELS(C), .WIDTH(W), .FRAC(F)) dut (
    .clk_in_i   (clk_in_i),
    .reset_i    (reset_i),
    .clk_en_i   (clk_en_i),
    .cfg_we_i   (cfg_we_i),
    .cfg_ch_i   (cfg_ch_i),
    .cfg_sel_i  (cfg_sel_i),
    .cfg_data_i (cfg_data_i),
    .sens_we_i  (sens_we_i),
    .sens_ch_i  (sens_ch_i),
    .sens_data_i(sens_data_i),
    .pid_o      (pid_o),
    .pid_valid_o(pid_valid_o),
    .busy_o     (busy_o),
    .overrun_o  (overrun_o)
  );

  always #5 clk_in_i = ~clk_in_i;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  longint mp[C], mi[C], md[C], msp[C], mlo[C], mup[C];
  longint moff[C], msens[C], minteg[C], meprev[C];
  logic [W-1:0] mout[C];
  logic [C-1:0] mvalid;
  bit     mbusy, movr;
  int     mcnt;
  logic [W-1:0] p_out;
  longint p_int, p_e;

  function automatic logic [C*W-1:0] exp_pid();
    return {mout[3], mout[2], mout[1], mout[0]};
  endfunction

  function automatic void calc(input int k, output logic [W-1:0] o,
                               output longint ni, output longint e);
    longint s, d, acc, v;
    e = msp[k] - msens[k];
    s = minteg[k] + e;
    if (s > mup[k]) s = mup[k];
    if (s < mlo[k]) s = mlo[k];
    d = e - meprev[k];
    acc = mp[k] * e + mi[k] * s + md[k] * d;
    v = (acc >>> F) + moff[k];
    if (v < 0) v = 0;
    else if (v > 65535) v = 65535;
    o = W'(v);
    ni = s;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < C; k++) begin
      mp[k] = 0; mi[k] = 0; md[k] = 0; msp[k] = 0;
      moff[k] = 0; msens[k] = 0; minteg[k] = 0; meprev[k] = 0;
      mlo[k] = -32768; mup[k] = 32767; mout[k] = '0;
    end
    mvalid = '0; mbusy = 0; movr = 0; mcnt = 0;
  endfunction

  task automatic step(input bit tk, input bit cwe, input int cch,
                      input int csel, input logic [W-1:0] cd,
                      input bit swe, input int sch,
                      input logic [W-1:0] sd);
    int k;
    @(negedge clk_in_i);
    clk_en_i = tk; cfg_we_i = cwe; cfg_ch_i = 2'(cch);
    cfg_sel_i = 3'(csel); cfg_data_i = cd;
    sens_we_i = swe; sens_ch_i = 2'(sch); sens_data_i = sd;
    @(posedge clk_in_i);
    mvalid = '0;
    if (mbusy) begin
      mcnt++;
      k = (mcnt - 1) / 4;
      if (mcnt % 4 == 1) calc(k, p_out, p_int, p_e);
      if (mcnt % 4 == 0) begin
        mout[k] = p_out; minteg[k] = p_int;
        meprev[k] = p_e; mvalid[k] = 1'b1;
        if (mcnt == 4 * C) mbusy = 0;
      end
      if (tk) movr = 1;
    end else if (tk) begin
      mbusy = 1; mcnt = 0;
    end
    if (cwe && cch < C) begin
      case (csel)
        0: mp[cch] = longint'($signed(cd));
        1: mi[cch] = longint'($signed(cd));
        2: md[cch] = longint'($signed(cd));
        3: msp[cch] = longint'(cd);
        4: mlo[cch] = longint'($signed(cd));
        5: mup[cch] = longint'($signed(cd));
        6: moff[cch] = longint'(cd);
        default: ;
      endcase
    end
    if (swe && sch < C) msens[sch] = longint'(sd);
    #1;
  endtask

  task automatic idle(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      step(0, 0, 0, 0, '0, 0, 0, '0);
      pulses += $countones(pid_valid_o);
    end
  endtask

  task automatic cfg(input int ch, input int sel, input logic [W-1:0] d);
    step(0, 1, ch, sel, d, 0, 0, '0);
  endtask

  task automatic sens(input int ch, input logic [W-1:0] d);
    step(0, 0, 0, 0, '0, 1, ch, d);
  endtask

  task automatic tick();
    step(1, 0, 0, 0, '0, 0, 0, '0);
  endtask

  task automatic apply_reset();
    clk_en_i = 0; cfg_we_i = 0; sens_we_i = 0;
    cfg_ch_i = '0; cfg_sel_i = '0; cfg_data_i = '0;
    sens_ch_i = '0; sens_data_i = '0;
    reset_i = 0;
    model_reset();
    repeat (3) @(posedge clk_in_i);
    @(negedge clk_in_i);
    reset_i = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_errors++; $display("FAIL reset_busy got %b want 0", busy_o);
    end
    n_checks++;
    if (overrun_o !== 1'b0) begin
      n_errors++; $display("FAIL reset_overrun got %b want 0", overrun_o);
    end
    n_checks++;
    if (pid_o !== '0) begin
      n_errors++; $display("FAIL reset_pid got %h want 0", pid_o);
    end
    n_checks++;
    if (pid_valid_o !== '0) begin
      n_errors++; $display("FAIL reset_valid got %b want 0", pid_valid_o);
    end
  endtask

  task automatic test_basic();
    int p;
    cfg(0, 0, 16'h0100);
    cfg(0, 3, 16'd1000);
    sens(0, 16'd400);
    tick();
    idle(4, p);
    n_checks++;
    if (pid_valid_o !== 4'b0001 || pid_o[15:0] !== 16'd600) begin
      n_errors++;
      $display("FAIL basic_ch0 got v=%b o=%0d want v=0001 o=600",
               pid_valid_o, pid_o[15:0]);
    end
    idle(11, p);
    n_checks++;
    if (busy_o !== 1'b1) begin
      n_errors++; $display("FAIL basic_busy_t15 got %b want 1", busy_o);
    end
    idle(1, p);
    n_checks++;
    if (busy_o !== 1'b0 || pid_valid_o !== 4'b1000) begin
      n_errors++;
      $display("FAIL basic_busy_t16 got b=%b v=%b want b=0 v=1000",
               busy_o, pid_valid_o);
    end
    n_checks++;
    if (pid_o !== exp_pid()) begin
      n_errors++; $display("FAIL basic_model got %h want %h", pid_o, exp_pid());
    end
  endtask

  task automatic test_saturate();
    int p;
    cfg(1, 0, 16'h0100);
    sens(1, 16'd500);
    tick();
    idle(16, p);
    n_checks++;
    if (pid_o[31:16] !== 16'd0) begin
      n_errors++; $display("FAIL sat_low got %0d want 0", pid_o[31:16]);
    end
    cfg(1, 6, 16'hFFF0);
    cfg(1, 3, 16'd500);
    sens(1, 16'd0);
    tick();
    idle(16, p);
    n_checks++;
    if (pid_o[31:16] !== 16'hFFFF) begin
      n_errors++; $display("FAIL sat_high got %h want ffff", pid_o[31:16]);
    end
  endtask

  task automatic test_integral();
    int p;
    logic [W-1:0] want[3];
    want[0] = 16'd600; want[1] = 16'd1000; want[2] = 16'd1000;
    cfg(2, 1, 16'h0100);
    cfg(2, 5, 16'd1000);
    cfg(2, 3, 16'd600);
    for (int t = 0; t < 3; t++) begin
      tick();
      idle(16, p);
      n_checks++;
      if (pid_o[47:32] !== want[t]) begin
        n_errors++;
        $display("FAIL integ_tick%0d got %0d want %0d",
                 t, pid_o[47:32], want[t]);
      end
    end
  endtask

  task automatic test_derivative();
    int p;
    cfg(3, 2, 16'h0100);
    cfg(3, 3, 16'd100);
    tick();
    idle(16, p);
    n_checks++;
    if (pid_o[63:48] !== 16'd100) begin
      n_errors++; $display("FAIL deriv_1 got %0d want 100", pid_o[63:48]);
    end
    cfg(3, 3, 16'd300);
    tick();
    idle(16, p);
    n_checks++;
    if (pid_o[63:48] !== 16'd200) begin
      n_errors++; $display("FAIL deriv_2 got %0d want 200", pid_o[63:48]);
    end
  endtask

  task automatic test_overrun();
    int p, total;
    tick();
    idle(1, p);
    total = p;
    tick();
    n_checks++;
    if (overrun_o !== 1'b1) begin
      n_errors++; $display("FAIL overrun_set got %b want 1", overrun_o);
    end
    total += $countones(pid_valid_o);
    idle(20, p);
    total += p;
    n_checks++;
    if (total != 4) begin
      n_errors++; $display("FAIL overrun_pulses got %0d want 4", total);
    end
    n_checks++;
    if (overrun_o !== 1'b1 || busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL overrun_sticky got o=%b b=%b want o=1 b=0",
               overrun_o, busy_o);
    end
  endtask

  task automatic test_reset_mid();
    int p, cnt;
    tick();
    idle(5, p);
    n_checks++;
    if (pid_o[15:0] !== 16'd600 || busy_o !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_pre got o=%0d b=%b want o=600 b=1",
               pid_o[15:0], busy_o);
    end
    @(negedge clk_in_i);
    reset_i = 0;
    model_reset();
    #1;
    n_checks++;
    if (busy_o !== 1'b0 || pid_o !== '0 || overrun_o !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_async got b=%b o=%h ov=%b want 0 0 0",
               busy_o, pid_o, overrun_o);
    end
    cnt = 0;
    repeat (3) begin
      @(posedge clk_in_i); #1;
      cnt += $countones(pid_valid_o);
    end
    @(negedge clk_in_i);
    reset_i = 1;
    idle(12, p);
    cnt += p;
    n_checks++;
    if (cnt != 0 || busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_abort got pulses=%0d b=%b want 0 0", cnt, busy_o);
    end
    cfg(0, 0, 16'h0100);
    cfg(0, 3, 16'd1000);
    sens(0, 16'd400);
    tick();
    idle(4, p);
    n_checks++;
    if (pid_valid_o !== 4'b0001 || pid_o[15:0] !== 16'd600) begin
      n_errors++;
      $display("FAIL mid_restart got v=%b o=%0d want v=0001 o=600",
               pid_valid_o, pid_o[15:0]);
    end
    idle(12, p);
    n_checks++;
    if (p != 3 || busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_tail got pulses=%0d b=%b want 3 0", p, busy_o);
    end
  endtask

  task automatic test_random();
    bit tk, cwe, swe;
    int cch, csel, sch;
    logic [W-1:0] cd, sd;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      tk   = ($urandom_range(0, 99) < 8);
      cwe  = ($urandom_range(0, 2) == 0);
      cch  = $urandom_range(0, C - 1);
      csel = $urandom_range(0, 7);
      if (csel <= 2) cd = W'($urandom_range(0, 1023) - 512);
      else cd = W'($urandom);
      swe  = ($urandom_range(0, 2) == 0);
      sch  = $urandom_range(0, C - 1);
      sd   = W'($urandom);
      step(tk, cwe, cch, csel, cd, swe, sch, sd);
      n_checks++;
      if (pid_o !== exp_pid()) begin
        n_errors++;
        $display("FAIL rand_pid cyc %0d got %h want %h", i, pid_o, exp_pid());
      end
      n_checks++;
      if (pid_valid_o !== mvalid) begin
        n_errors++;
        $display("FAIL rand_valid cyc %0d got %b want %b",
                 i, pid_valid_o, mvalid);
      end
      n_checks++;
      if (busy_o !== mbusy) begin
        n_errors++;
        $display("FAIL rand_busy cyc %0d got %b want %b", i, busy_o, mbusy);
      end
      n_checks++;
      if (overrun_o !== movr) begin
        n_errors++;
        $display("FAIL rand_ovr cyc %0d got %b want %b", i, overrun_o, movr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_integral();
    test_derivative();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pid_multi_ctrl.md
PID_MULTI_CTRL -- requirements
Module: pid_multi_ctrl

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent control loops, range 1-16.
REQ-002 SHALL have parameter WIDTH, default 16: data and coefficient width.
REQ-003 SHALL have parameter FRAC, default 8: fractional bits of the P/I/D coefficients, range 0 to WIDTH-1.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; the clock port is clk_in_i and the reset port is reset_i.
REQ-005 SHALL have ports:
- clk_in_i  in  1  system clock
- reset_i  in  1  async active-low reset
- clk_en_i  in  1  sample tick, one cycle wide
- cfg_we_i  in  1  config write strobe
- cfg_ch_i  in  CW  config channel index, CW = max(1, clog2(CHANNELS))
- cfg_sel_i  in  3  register select: 0 P, 1 I, 2 D, 3 SP, 4 INT_LOW, 5 INT_UP, 6 OFFSET; 7 reserved
- cfg_data_i  in  WIDTH  config write data
- sens_we_i  in  1  sensor sample strobe
- sens_ch_i  in  CW  sensor channel index
- sens_data_i  in  WIDTH  sensor sample, unsigned
- pid_o  out  CHANNELS*WIDTH  per-channel output, unsigned; channel k occupies bits [k*WIDTH +: WIDTH]
- pid_valid_o  out  CHANNELS  one-cycle update pulse per channel
- busy_o  out  1  computation sequence in progress
- overrun_o  out  1  sticky flag: tick arrived while busy

Function
REQ-006 Number formats SHALL be: P, I and D signed, Q(WIDTH-FRAC).FRAC; SP, sensor and OFFSET unsigned; INT_LOW and INT_UP signed WIDTH.
REQ-007 A write with cfg_we_i=1 SHALL update the selected register of channel cfg_ch_i on that edge.
- Writes with cfg_sel_i=7 SHALL be ignored.
- Writes with cfg_ch_i >= CHANNELS SHALL be ignored.
REQ-008 A write with sens_we_i=1 SHALL store sens_data_i for channel sens_ch_i; an index >= CHANNELS SHALL be ignored.
- Config and sensor writes SHALL be independent and both accepted in the same cycle.
REQ-009 FSM states SHALL be IDLE, LOAD, MULT, SUM, WRITE.
- IDLE->LOAD on an accepted tick.
- LOAD->MULT->SUM->WRITE, one cycle each.
- WRITE->LOAD if channels remain, else WRITE->IDLE.
REQ-010 A tick (clk_en_i=1) SHALL be accepted only while busy_o=0; a tick sampled while busy_o=1 SHALL be ignored and SHALL set overrun_o.
REQ-011 busy_o SHALL rise on the edge that accepts the tick and fall on the final WRITE edge; one sequence takes 4*CHANNELS cycles.
REQ-012 LOAD SHALL snapshot the channel's registers and sensor value.
- Writes landing after LOAD SHALL take effect at the next tick.
- A write landing on the LOAD edge itself SHALL NOT be seen by that LOAD.
REQ-013 Per channel, the block SHALL compute:
- e = SP - S, signed WIDTH+1
- integ' = clamp(integ + e, INT_LOW, INT_UP); test upper bound first, then lower; the lower bound wins if INT_LOW > INT_UP
- deriv = e - e_prev
- acc = P*e + I*integ' + D*deriv, full precision with no internal overflow
- out = (acc >>> FRAC) + OFFSET, saturated to [0, 2^WIDTH-1]
REQ-014 On the WRITE edge the block SHALL:
- update integ and e_prev (e_prev = e);
- drive pid_o slice k to out;
- pulse pid_valid_o[k] for exactly that cycle.
REQ-015 Channels SHALL be processed in order 0..CHANNELS-1; for a tick accepted at edge T, channel k's output updates at edge T+4(k+1).
REQ-016 pid_o SHALL hold its value between updates.

Reset
REQ-017 While reset_i=0, the block SHALL asynchronously force the FSM to IDLE and set:
- busy_o, overrun_o, pid_valid_o, pid_o = 0
- P, I, D, SP, OFFSET, sensor, integ, e_prev = 0
- INT_LOW = -2^(WIDTH-1), INT_UP = 2^(WIDTH-1)-1
REQ-018 Reset asserted mid-sequence SHALL abort the sequence with no further pid_valid_o pulses; after release, the block SHALL wait in IDLE for a new tick.

Verification (CHANNELS=4, WIDTH=16, FRAC=8)
REQ-019 Ch0 with P=0x0100, SP=1000, S=400, other coefficients 0, tick at T -> pid_o[15:0]=600 and pid_valid_o[0]=1 at T+4; busy_o falls at T+16.
REQ-020 Ch1 with P=0x0100, SP=0, S=500 -> output saturates to 0; with OFFSET=0xFFF0 and SP=500, S=0 -> output saturates to 0xFFFF.
REQ-021 Ch2 with I=0x0100, INT_UP=1000, e=600 held over three ticks -> integ and output 600, 1000, 1000.
REQ-022 Ch3 with D=0x0100, e=100 then e=300 over two ticks -> outputs 100 then 200.
REQ-023 Tick at T, second tick at T+2 -> second tick ignored, overrun_o=1 until reset, exactly four pid_valid_o pulses.
REQ-024 reset_i low at T+6 during a sequence -> busy_o=0 and pid_o=0 immediately; no pulse for ch1-ch3; the next tick after release recomputes normally.
